// File: rtl/player_hit_pkg.sv
// Shared types and constants for the player hit judge.
// Contents: FSM state enum and the enemy-bullet geometry constants.
package player_hit_pkg;

    typedef enum logic [1:0] {
        ALIVE,
        HIT,
        INVULN,
        DEAD
    } state_e;

    localparam int unsigned BULLET_W = 10;
    localparam int unsigned BULLET_H = 40;
    localparam int unsigned Y_OFFSET = 480;  // eb_y carries this bias over screen y
    localparam int unsigned Y_LIMIT  = 960;  // eb_y above this means bullet is off-field

endpackage

// File: rtl/player_hit_judge_if.sv
// Enemy-bullet <-> player hit-judge link.
// Signals:
//   eb_x, eb_y        bullet left x / biased top y (bullet block drives)
//   enemybullet_exist bullet live flag; dropping it acknowledges boom
//   boom              hit notification, held until acknowledged or timed out
// Modports: master = bullet block, slave = hit judge.
interface player_hit_judge_if;

    logic [9:0] eb_x;
    logic [9:0] eb_y;
    logic       enemybullet_exist;
    logic       boom;

    modport master (
        output eb_x,
        output eb_y,
        output enemybullet_exist,
        input  boom
    );

    modport slave (
        input  eb_x,
        input  eb_y,
        input  enemybullet_exist,
        output boom
    );

endinterface

// File: rtl/hit_box_overlap.sv
// Combinational axis-aligned rectangle overlap test in 11-bit unsigned math.
// Ports:
//   obj_x_i, obj_y_i  top-left of the moving object (OBJ_W x OBJ_H)
//   box_x_i, box_y_i  top-left of the target box (BOX_W x BOX_H)
//   overlap_o         1 when the open rectangles intersect (touching edges do not count)
// Inputs are 10-bit values zero-extended (plus any bias), so sums never wrap.
module hit_box_overlap #(
    parameter int unsigned BOX_W = 46,
    parameter int unsigned BOX_H = 40,
    parameter int unsigned OBJ_W = 10,
    parameter int unsigned OBJ_H = 40
) (
    input  logic [10:0] obj_x_i,
    input  logic [10:0] obj_y_i,
    input  logic [10:0] box_x_i,
    input  logic [10:0] box_y_i,
    output logic        overlap_o
);

    always_comb begin
        overlap_o = (obj_x_i < box_x_i + 11'(BOX_W)) &&
                    (obj_x_i + 11'(OBJ_W) > box_x_i) &&
                    (obj_y_i < box_y_i + 11'(BOX_H)) &&
                    (obj_y_i + 11'(OBJ_H) > box_y_i);
    end

endmodule

// File: rtl/player_hit_judge.sv
// Player hit judge: detects enemy-bullet overlap with the player sprite, drives the boom
// handshake back to the bullet block, and owns lives, post-hit invulnerability blink and
// game-over.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   frame_tick        one-clk pulse per game frame
//   p_x, p_y          player top-left, screen coordinates
//   shield_arm        pulse arming the shield (SHIELD_EN builds only)
//   eb_if (slave)     eb_x, eb_y, enemybullet_exist in; boom out
//   lives, player_visible, game_over, hit_count, shield_active   status outputs
// Build option: define SHIELD_EN to enable the one-shot shield.
module player_hit_judge
    import player_hit_pkg::*;
#(
    parameter int unsigned PW            = 46,
    parameter int unsigned PH            = 40,
    parameter int unsigned START_LIVES   = 3,
    parameter int unsigned INVULN_FRAMES = 120,
    parameter int unsigned BOOM_TIMEOUT  = 4,
    parameter int unsigned BLINK_DIV     = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     frame_tick,
    input  logic [9:0]               p_x,
    input  logic [9:0]               p_y,
    input  logic                     shield_arm,
    player_hit_judge_if.slave        eb_if,
    output logic [1:0]               lives,
    output logic                     player_visible,
    output logic                     game_over,
    output logic [7:0]               hit_count,
    output logic                     shield_active
);

    localparam int unsigned ToW    = $clog2(BOOM_TIMEOUT + 1);
    localparam int unsigned InvW   = $clog2(INVULN_FRAMES + 1);
    localparam int unsigned BlinkW = $clog2(BLINK_DIV + 1);

    localparam logic [ToW-1:0]    ToLast    = ToW'(BOOM_TIMEOUT - 1);
    localparam logic [InvW-1:0]   InvLast   = InvW'(INVULN_FRAMES - 1);
    localparam logic [BlinkW-1:0] BlinkLast = BlinkW'(BLINK_DIV - 1);

    state_e            state_q;
    logic              boom_q;
    logic [1:0]        lives_q;
    logic              visible_q;
    logic              game_over_q;
    logic [7:0]        hit_cnt_q;
    logic              shield_q;
    logic              shield_hit_q;  // current HIT was absorbed by the shield
    logic [ToW-1:0]    to_cnt_q;
    logic [InvW-1:0]   inv_cnt_q;
    logic [BlinkW-1:0] blink_cnt_q;

    logic [10:0] eb_x_w;
    logic [10:0] eb_y_w;
    logic [10:0] p_x_w;
    logic [10:0] p_y_w;
    logic        box_hit;
    logic        overlap;
    logic        ack;

    // Player y is moved into the bullet's biased coordinate space.
    assign eb_x_w = {1'b0, eb_if.eb_x};
    assign eb_y_w = {1'b0, eb_if.eb_y};
    assign p_x_w  = {1'b0, p_x};
    assign p_y_w  = {1'b0, p_y} + 11'(Y_OFFSET);

    hit_box_overlap #(
        .BOX_W (PW),
        .BOX_H (PH),
        .OBJ_W (BULLET_W),
        .OBJ_H (BULLET_H)
    ) u_overlap (
        .obj_x_i   (eb_x_w),
        .obj_y_i   (eb_y_w),
        .box_x_i   (p_x_w),
        .box_y_i   (p_y_w),
        .overlap_o (box_hit)
    );

    assign overlap = box_hit && (eb_y_w <= 11'(Y_LIMIT)) && eb_if.enemybullet_exist;
    assign ack     = !eb_if.enemybullet_exist;

`ifndef SHIELD_EN
    logic unused_shield_arm;
    assign unused_shield_arm = shield_arm;
`endif

    // The overlap is registered straight into state/boom, so an overlap in cycle N
    // shows as boom=1 in cycle N+1.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ALIVE;
            boom_q       <= 1'b0;
            lives_q      <= 2'(START_LIVES);
            visible_q    <= 1'b1;
            game_over_q  <= 1'b0;
            hit_cnt_q    <= 8'd0;
            shield_q     <= 1'b0;
            shield_hit_q <= 1'b0;
            to_cnt_q     <= '0;
            inv_cnt_q    <= '0;
            blink_cnt_q  <= '0;
        end else begin
`ifdef SHIELD_EN
            if (shield_arm) begin
                shield_q <= 1'b1;
            end
`endif
            unique case (state_q)
                ALIVE: begin
                    if (overlap) begin
                        state_q  <= HIT;
                        boom_q   <= 1'b1;
                        to_cnt_q <= '0;
                        if (hit_cnt_q != 8'hFF) begin
                            hit_cnt_q <= hit_cnt_q + 8'd1;
                        end
                        if (shield_q) begin
                            // Later assignment overrides a same-cycle arm pulse.
                            shield_q     <= 1'b0;
                            shield_hit_q <= 1'b1;
                        end else begin
                            shield_hit_q <= 1'b0;
                            if (lives_q != 2'd0) begin
                                lives_q <= lives_q - 2'd1;
                            end
                        end
                    end
                end
                HIT: begin
                    // Acknowledge takes priority; a coincident frame tick is irrelevant.
                    if (ack || (frame_tick && to_cnt_q == ToLast)) begin
                        boom_q   <= 1'b0;
                        to_cnt_q <= '0;
                        if (shield_hit_q) begin
                            state_q <= ALIVE;
                        end else if (lives_q == 2'd0) begin
                            state_q     <= DEAD;
                            game_over_q <= 1'b1;
                            visible_q   <= 1'b0;
                        end else begin
                            state_q     <= INVULN;
                            visible_q   <= 1'b0;
                            inv_cnt_q   <= '0;
                            blink_cnt_q <= '0;
                        end
                    end else if (frame_tick) begin
                        to_cnt_q <= to_cnt_q + 1'b1;
                    end
                end
                INVULN: begin
                    if (frame_tick) begin
                        if (inv_cnt_q == InvLast) begin
                            state_q     <= ALIVE;
                            visible_q   <= 1'b1;
                            inv_cnt_q   <= '0;
                            blink_cnt_q <= '0;
                        end else begin
                            inv_cnt_q <= inv_cnt_q + 1'b1;
                            if (blink_cnt_q == BlinkLast) begin
                                blink_cnt_q <= '0;
                                visible_q   <= ~visible_q;
                            end else begin
                                blink_cnt_q <= blink_cnt_q + 1'b1;
                            end
                        end
                    end
                end
                DEAD: begin
                    boom_q      <= 1'b0;
                    visible_q   <= 1'b0;
                    game_over_q <= 1'b1;
                end
                default: state_q <= ALIVE;
            endcase
        end
    end

    assign eb_if.boom     = boom_q;
    assign lives          = lives_q;
    assign player_visible = visible_q;
    assign game_over      = game_over_q;
    assign hit_count      = hit_cnt_q;
    assign shield_active  = shield_q;

endmodule

// File: tb/tb_player_hit_judge.sv
// Directed self-checking bench for player_hit_judge (default parameters).
module tb_player_hit_judge;

`ifdef SHIELD_EN
    localparam bit Shield = 1'b1;
`else
    localparam bit Shield = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       frame_tick = 1'b0;
    logic [9:0] p_x = 10'd100;
    logic [9:0] p_y = 10'd400;
    logic       shield_arm = 1'b0;
    logic [1:0] lives;
    logic       player_visible;
    logic       game_over;
    logic [7:0] hit_count;
    logic       shield_active;

    int unsigned passed = 0;
    int unsigned total  = 0;

    player_hit_judge_if eb_if ();

    player_hit_judge dut (
        .clk            (clk),
        .rst            (rst),
        .frame_tick     (frame_tick),
        .p_x            (p_x),
        .p_y            (p_y),
        .shield_arm     (shield_arm),
        .eb_if          (eb_if),
        .lives          (lives),
        .player_visible (player_visible),
        .game_over      (game_over),
        .hit_count      (hit_count),
        .shield_active  (shield_active)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic frame();
        frame_tick = 1'b1;
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    task automatic park();
        eb_if.eb_x = 10'd500;
        eb_if.eb_y = 10'd0;
    endtask

    initial begin
        eb_if.enemybullet_exist = 1'b1;
        park();
        step();
        step();
        rst = 1'b0;

        // Reset state
        chk("rst_boom", eb_if.boom, 0);
        chk("rst_lives", lives, 3);
        chk("rst_vis", player_visible, 1);
        chk("rst_gameover", game_over, 0);
        chk("rst_hitcount", hit_count, 0);
        chk("rst_shield", shield_active, 0);

        // Boundary: bullet touching player's right edge does not hit
        eb_if.eb_x = 10'd146;
        eb_if.eb_y = 10'd870;
        step();
        step();
        chk("edge_x146", eb_if.boom, 0);
        // Boundary: eb_y=961 with overlapping box (player y 470 -> 950..990)
        p_y = 10'd470;
        eb_if.eb_x = 10'd120;
        eb_if.eb_y = 10'd961;
        step();
        step();
        chk("edge_y961", eb_if.boom, 0);
        p_y = 10'd400;
        park();
        step();

        // First hit at eb_x=145: boom one cycle after overlap
        eb_if.eb_x = 10'd145;
        eb_if.eb_y = 10'd870;
        #1;
        chk("hit1_before", eb_if.boom, 0);
        step();
        chk("hit1_boom", eb_if.boom, 1);
        chk("hit1_lives", lives, 2);
        chk("hit1_count", hit_count, 1);
        step();
        chk("hit1_hold", eb_if.boom, 1);
        // Acknowledge
        eb_if.enemybullet_exist = 1'b0;
        step();
        chk("ack_release", eb_if.boom, 0);
        chk("inv_vis0", player_visible, 0);
        eb_if.enemybullet_exist = 1'b1;  // overlap persists but is ignored

        // Invulnerability blink
        frames(7);
        chk("blink_t7", player_visible, 0);
        frame();
        chk("blink_t8", player_visible, 1);
        frames(8);
        chk("blink_t16", player_visible, 0);
        frames(103);
        chk("inv_t119_boom", eb_if.boom, 0);
        chk("inv_t119_lives", lives, 2);
        frame();
        chk("inv_exit_vis", player_visible, 1);
        chk("inv_exit_boom", eb_if.boom, 0);
        // Persisting overlap is a new hit one cycle after re-entering ALIVE
        step();
        chk("hit2_boom", eb_if.boom, 1);
        chk("hit2_lives", lives, 1);
        chk("hit2_count", hit_count, 2);

        // Timeout release with exist held high
        frames(3);
        chk("to_t3", eb_if.boom, 1);
        frame();
        chk("to_t4", eb_if.boom, 0);
        chk("to_lives", lives, 1);
        chk("to_vis", player_visible, 0);

        // Third hit -> dead
        frames(120);
        chk("inv2_exit_vis", player_visible, 1);
        step();
        chk("hit3_boom", eb_if.boom, 1);
        chk("hit3_lives", lives, 0);
        chk("hit3_count", hit_count, 3);
        eb_if.enemybullet_exist = 1'b0;
        step();
        chk("dead_boom", eb_if.boom, 0);
        chk("dead_gameover", game_over, 1);
        chk("dead_vis", player_visible, 0);
        eb_if.enemybullet_exist = 1'b1;
        frames(5);
        step();
        chk("dead_ignore_boom", eb_if.boom, 0);
        chk("dead_ignore_lives", lives, 0);
        chk("dead_ignore_count", hit_count, 3);
        chk("dead_sticky", game_over, 1);

        // Reset recovers
        park();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rst2_lives", lives, 3);
        chk("rst2_gameover", game_over, 0);
        chk("rst2_vis", player_visible, 1);
        chk("rst2_count", hit_count, 0);

        // Shield (expectations depend on build)
        shield_arm = 1'b1;
        step();
        shield_arm = 1'b0;
        chk("shield_armed", shield_active, 32'(Shield));
        eb_if.eb_x = 10'd120;
        eb_if.eb_y = 10'd870;
        step();
        chk("shield_boom", eb_if.boom, 1);
        chk("shield_lives", lives, Shield ? 3 : 2);
        chk("shield_cleared", shield_active, 0);
        chk("shield_count", hit_count, 1);
        park();
        eb_if.enemybullet_exist = 1'b0;
        step();
        eb_if.enemybullet_exist = 1'b1;
        chk("shield_release", eb_if.boom, 0);
        chk("shield_vis", player_visible, 32'(Shield));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
